sram_1rw_arbiter: RTL and testbench
===================================

SRAM_1RW_ARBITER -- requirements
Module: sram_1rw_arbiter

Interface
REQ-001 Parameter BITS, default 256: data and mask width.
REQ-002 Parameter ADDR_WIDTH, default 12: word address width (4096 words).
REQ-003 Ports, one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous reset, active-high
- pN_req_valid  in  1  request valid, N=0,1
- pN_req_ready  out  1  request accepted when valid&ready
- pN_req_we  in  1  1=masked write, 0=read
- pN_req_addr  in  ADDR_WIDTH  word address
- pN_req_wdata  in  BITS  write data
- pN_req_wmask  in  BITS  per-bit write enable
- pN_resp_valid  out  1  read data valid
- pN_resp_ready  in  1  read data consumed when valid&ready
- pN_resp_rdata  out  BITS  read data
- sram_ce_in  out  1  macro chip enable
- sram_we_in  out  1  macro write enable
- sram_addr_in  out  ADDR_WIDTH  macro address
- sram_wd_in  out  BITS  macro write data
- sram_w_mask_in  out  BITS  macro write mask
- sram_rd_out  in  BITS  macro read data, valid the cycle after a ce=1 read edge

Function
REQ-004 Macro access per cycle: at most one; the granted request drives the sram_* outputs combinationally in the cycle of its handshake, and the macro samples them at the next rising edge.
REQ-005 Idle cycle: sram_ce_in=0, sram_we_in=0, sram_addr_in=0, sram_wd_in=0, sram_w_mask_in=0 (no X on macro inputs).
REQ-006 Read eligibility, port N: pN_req_we=0 and occ_N - (pN_resp_valid&pN_resp_ready) < 2, where occ_N = response FIFO count + in-flight read flag.
REQ-007 Write eligibility: pN_req_we=1, always eligible.
REQ-008 Eligible port = pN_req_valid & eligibility; pN_req_ready asserted only to the granted port, never to both.
REQ-009 Arbitration: round-robin. When exactly one port is eligible, it wins. When both are eligible, the port other than last_grant wins; last_grant updates only on a handshake.
REQ-010 Eligibility and grant are independent of the other port's data fields; ready may depend on the port's own valid and we (valid-before-ready permitted).
REQ-011 Read pipeline: handshake at edge t sets inflight_N; sram_rd_out is captured into port N's response FIFO at edge t+1; pN_resp_valid is high from cycle after edge t+1. Minimum request-to-response latency is 2 edges.
REQ-012 Response FIFO: 2 entries per port, in-order; pN_resp_rdata = head entry; pN_resp_valid = count>0.
REQ-013 Simultaneous push (capture) and pop (valid&ready) leave the count unchanged. The count never exceeds 2, guaranteed by REQ-006.
REQ-014 sram_rd_out is sampled only when an in-flight read exists; it is ignored in all other cycles, including after writes.
REQ-015 Writes produce no response; a write issued at edge t is visible to any read issued at edge t+1 or later, from either port.
REQ-016 Single port, 1-entry-free FIFO, continuous reads with resp_ready=1: one read accepted per cycle, no bubbles.
REQ-017 Responses return only to the issuing port; the two ports' response streams are independent.

Reset
REQ-018 reset=1 at a rising edge: FIFOs emptied, inflight flags cleared, last_grant=1 (port 0 wins first contention).
REQ-019 During and after reset, all pN_req_ready=0 and pN_resp_valid=0, and sram_* take the idle values of REQ-005 until the first post-reset handshake.
REQ-020 Reset mid-operation discards in-flight reads and buffered responses; a write handshaken before the reset edge still completes in the macro.

Verification
REQ-021 Write then read: p0 writes addr 0x005, data all 0xA5, mask all 1; then p0 reads 0x005 -> p0_resp_rdata=all 0xA5, resp_valid 2 edges after the read handshake.
REQ-022 Masked write: word=0, write data all 1s with mask 0x00FF (low 8 bits) -> read returns 0x00FF.
REQ-023 Contention: both ports valid every cycle, continuous reads -> grants alternate p0,p1,p0,... with the first grant to p0 after reset.
REQ-024 Backpressure: p1 reads 3 times with p1_resp_ready=0 -> 2 reads accepted, third stalls with ready=0; one pop -> third accepted; all data arrives in order.
REQ-025 Idle/X: no requests -> sram_ce_in=0 every cycle; with sram_rd_out driven X, no resp_valid is asserted.
REQ-026 Reset mid-read: p0 read handshaken, reset asserted next edge -> p0_resp_valid stays 0, FIFOs empty, and the next contention grants p0.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// Two-port arbiter in front of a single-port (1RW) SRAM macro.
// Round-robin grant, one macro access per cycle, 2-entry in-order response FIFO per port.
module sram_1rw_arbiter #(
  parameter int unsigned BITS       = 256,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [BITS-1:0]       p0_req_wdata,
  input  logic [BITS-1:0]       p0_req_wmask,
  output logic                  p0_resp_valid,
  input  logic                  p0_resp_ready,
  output logic [BITS-1:0]       p0_resp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [BITS-1:0]       p1_req_wdata,
  input  logic [BITS-1:0]       p1_req_wmask,
  output logic                  p1_resp_valid,
  input  logic                  p1_resp_ready,
  output logic [BITS-1:0]       p1_resp_rdata,
  output logic                  sram_ce_in,
  output logic                  sram_we_in,
  output logic [ADDR_WIDTH-1:0] sram_addr_in,
  output logic [BITS-1:0]       sram_wd_in,
  output logic [BITS-1:0]       sram_w_mask_in,
  input  logic [BITS-1:0]       sram_rd_out
);

  logic [1:0]            req_valid, req_we, resp_ready;
  logic [1:0]            elig, grant, pop, push;
  logic                  sel;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [BITS-1:0]       req_wdata [2];
  logic [BITS-1:0]       req_wmask [2];
  logic [2:0]            occ       [2];

  logic [1:0]            inflight_q, inflight_d;
  logic [1:0]            count_q   [2];
  logic [1:0]            count_d   [2];
  logic [BITS-1:0]       fifo_q    [2][2];
  logic [BITS-1:0]       fifo_d    [2][2];
  logic                  last_grant_q, last_grant_d;

  assign req_valid  = {p1_req_valid, p0_req_valid};
  assign req_we     = {p1_req_we, p0_req_we};
  assign resp_ready = {p1_resp_ready, p0_resp_ready};
  assign req_addr[0]  = p0_req_addr;
  assign req_addr[1]  = p1_req_addr;
  assign req_wdata[0] = p0_req_wdata;
  assign req_wdata[1] = p1_req_wdata;
  assign req_wmask[0] = p0_req_wmask;
  assign req_wmask[1] = p1_req_wmask;

  // A read may issue only if its response is guaranteed a FIFO slot.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      occ[n]  = {1'b0, count_q[n]} + {2'b00, inflight_q[n]};
      pop[n]  = (count_q[n] != 2'd0) && resp_ready[n];
      push[n] = inflight_q[n];
      elig[n] = !reset && req_valid[n] &&
                (req_we[n] || ((occ[n] - {2'b00, pop[n]}) < 3'd2));
    end
  end

  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant != 2'b00) last_grant_d = grant[1];
  end

  assign sel = grant[1];

  always_comb begin
    sram_ce_in     = 1'b0;
    sram_we_in     = 1'b0;
    sram_addr_in   = '0;
    sram_wd_in     = '0;
    sram_w_mask_in = '0;
    if (grant != 2'b00) begin
      sram_ce_in   = 1'b1;
      sram_we_in   = req_we[sel];
      sram_addr_in = req_addr[sel];
      if (req_we[sel]) begin
        sram_wd_in     = req_wdata[sel];
        sram_w_mask_in = req_wmask[sel];
      end
    end
  end

  // Shift-register FIFO: head is always entry 0; push lands behind any survivor of the pop.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      inflight_d[n] = grant[n] && !req_we[n];
      count_d[n]    = count_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
      fifo_d[n][0]  = fifo_q[n][0];
      fifo_d[n][1]  = fifo_q[n][1];
      if (pop[n]) fifo_d[n][0] = fifo_q[n][1];
      if (push[n]) begin
        if ((count_q[n] - {1'b0, pop[n]}) == 2'd0) fifo_d[n][0] = sram_rd_out;
        else                                       fifo_d[n][1] = sram_rd_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q   <= 2'b00;
      last_grant_q <= 1'b1;
      count_q[0]   <= 2'd0;
      count_q[1]   <= 2'd0;
    end else begin
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
      count_q[0]   <= count_d[0];
      count_q[1]   <= count_d[1];
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      fifo_q[n][0] <= fifo_d[n][0];
      fifo_q[n][1] <= fifo_d[n][1];
    end
  end

  assign p0_req_ready  = grant[0];
  assign p1_req_ready  = grant[1];
  assign p0_resp_valid = (count_q[0] != 2'd0);
  assign p1_resp_valid = (count_q[1] != 2'd0);
  assign p0_resp_rdata = fifo_q[0][0];
  assign p1_resp_rdata = fifo_q[1][0];

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter with a behavioural 1RW SRAM macro attached.
module tb_sram_1rw_arbiter;

  localparam int unsigned BITS = 256;
  localparam int unsigned AW   = 12;
  typedef logic [BITS-1:0] word_t;

  typedef struct {
    int             port;
    logic           we;
    logic [AW-1:0]  addr;
    word_t          wdata;
    word_t          wmask;
    word_t          exp;
  } vec_t;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic [1:0]    req_valid  = 2'b00;
  logic [1:0]    req_we     = 2'b00;
  logic [1:0]    resp_ready = 2'b00;
  logic [AW-1:0] req_addr  [2];
  word_t         req_wdata [2];
  word_t         req_wmask [2];

  wire           p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
  wire [BITS-1:0] p0_resp_rdata, p1_resp_rdata;
  wire           sram_ce_in, sram_we_in;
  wire [AW-1:0]  sram_addr_in;
  wire [BITS-1:0] sram_wd_in, sram_w_mask_in;
  wire [BITS-1:0] sram_rd_out;

  word_t mem [4096];
  word_t rd_q;
  logic  drive_x = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  sram_1rw_arbiter #(.BITS(BITS), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .p0_req_valid   (req_valid[0]),
    .p0_req_ready   (p0_req_ready),
    .p0_req_we      (req_we[0]),
    .p0_req_addr    (req_addr[0]),
    .p0_req_wdata   (req_wdata[0]),
    .p0_req_wmask   (req_wmask[0]),
    .p0_resp_valid  (p0_resp_valid),
    .p0_resp_ready  (resp_ready[0]),
    .p0_resp_rdata  (p0_resp_rdata),
    .p1_req_valid   (req_valid[1]),
    .p1_req_ready   (p1_req_ready),
    .p1_req_we      (req_we[1]),
    .p1_req_addr    (req_addr[1]),
    .p1_req_wdata   (req_wdata[1]),
    .p1_req_wmask   (req_wmask[1]),
    .p1_resp_valid  (p1_resp_valid),
    .p1_resp_ready  (resp_ready[1]),
    .p1_resp_rdata  (p1_resp_rdata),
    .sram_ce_in     (sram_ce_in),
    .sram_we_in     (sram_we_in),
    .sram_addr_in   (sram_addr_in),
    .sram_wd_in     (sram_wd_in),
    .sram_w_mask_in (sram_w_mask_in),
    .sram_rd_out    (sram_rd_out)
  );

  always #5 clk = ~clk;

  // Macro model: bit-masked write, read data valid the cycle after the read edge.
  always @(posedge clk) begin
    if (sram_ce_in) begin
      if (sram_we_in)
        mem[sram_addr_in] <= (mem[sram_addr_in] & ~sram_w_mask_in) |
                             (sram_wd_in & sram_w_mask_in);
      else
        rd_q <= mem[sram_addr_in];
    end
  end

  assign sram_rd_out = drive_x ? {BITS{1'bx}} : rd_q;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic ready_of(input int p);
    return (p == 1) ? p1_req_ready : p0_req_ready;
  endfunction

  function automatic logic valid_of(input int p);
    return (p == 1) ? p1_resp_valid : p0_resp_valid;
  endfunction

  function automatic word_t rdata_of(input int p);
    return (p == 1) ? p1_resp_rdata : p0_resp_rdata;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic do_req(input int p, input logic we, input logic [AW-1:0] addr,
                        input word_t wd, input word_t wm, input string name);
    bit done = 1'b0;
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_wdata[p] = wd;
    req_wmask[p] = wm;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (ready_of(p)) begin
        done = 1'b1;
        chk({name, "_addr"}, word_t'(sram_addr_in), word_t'(addr));
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: ready never asserted", name);
    end
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic get_resp(input int p, input word_t exp, input string name);
    bit done = 1'b0;
    resp_ready[p] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (valid_of(p)) begin
        done = 1'b1;
        chk(name, rdata_of(p), exp);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: resp_valid never asserted", name);
    end
    @(posedge clk);
    #1;
    resp_ready[p] = 1'b0;
  endtask

  word_t ones, a5, dead, hi128, mixed, pat123, cafe;
  vec_t  vecs [10];

  initial begin
    ones   = '1;
    a5     = {32{8'hA5}};
    dead   = {8{32'hDEADBEEF}};
    hi128  = {{128{1'b1}}, {128{1'b0}}};
    mixed  = {{4{32'hFFFFFFFF}}, {4{32'hDEADBEEF}}};
    pat123 = {8{32'h01234567}};
    cafe   = {8{32'hCAFEF00D}};

    vecs[0] = '{port: 0, we: 1'b1, addr: 12'h000, wdata: '0,   wmask: ones,        exp: '0};
    vecs[1] = '{port: 0, we: 1'b1, addr: 12'h000, wdata: ones, wmask: word_t'(8'hFF), exp: '0};
    vecs[2] = '{port: 0, we: 1'b0, addr: 12'h000, wdata: '0,   wmask: '0,          exp: word_t'(8'hFF)};
    vecs[3] = '{port: 1, we: 1'b1, addr: 12'h0A0, wdata: dead, wmask: ones,        exp: '0};
    vecs[4] = '{port: 0, we: 1'b0, addr: 12'h0A0, wdata: '0,   wmask: '0,          exp: dead};
    vecs[5] = '{port: 1, we: 1'b1, addr: 12'h0A0, wdata: ones, wmask: hi128,       exp: '0};
    vecs[6] = '{port: 1, we: 1'b0, addr: 12'h0A0, wdata: '0,   wmask: '0,          exp: mixed};
    vecs[7] = '{port: 0, we: 1'b1, addr: 12'hFFF, wdata: pat123, wmask: ones,      exp: '0};
    vecs[8] = '{port: 1, we: 1'b0, addr: 12'hFFF, wdata: '0,   wmask: '0,          exp: pat123};
    vecs[9] = '{port: 1, we: 1'b0, addr: 12'h005, wdata: '0,   wmask: '0,          exp: a5};

    for (int p = 0; p < 2; p++) begin
      req_addr[p]  = '0;
      req_wdata[p] = '0;
      req_wmask[p] = '0;
    end

    // Reset: requests held valid must not be accepted and the macro stays idle.
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", word_t'({p1_req_ready, p0_req_ready}), '0);
      chk("rst_resp_valid", word_t'({p1_resp_valid, p0_resp_valid}), '0);
      chk("rst_sram_ce", word_t'(sram_ce_in), '0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 2'b00;

    // Write then read with exact latency.
    do_req(0, 1'b1, 12'h005, a5, ones, "wr005");
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 12'h005;
    @(negedge clk);
    chk("rd005_ready", word_t'(p0_req_ready), word_t'(1'b1));
    chk("rd005_ce", word_t'({sram_ce_in, sram_we_in}), word_t'(2'b10));
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rd005_valid_early", word_t'(p0_resp_valid), '0);
    @(negedge clk);
    chk("rd005_valid", word_t'(p0_resp_valid), word_t'(1'b1));
    chk("rd005_data", p0_resp_rdata, a5);
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b0;
    @(negedge clk);
    chk("rd005_popped", word_t'(p0_resp_valid), '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
             $sformatf("vec%0d", i));
      if (!vecs[i].we) get_resp(vecs[i].port, vecs[i].exp, $sformatf("vec%0d_data", i));
    end

    // Contention right after reset: p0 first, then strict alternation.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    req_we      = 2'b00;
    req_addr[0] = 12'h005;
    req_addr[1] = 12'h0A0;
    resp_ready  = 2'b11;
    req_valid   = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant_%0d", k), word_t'({p1_req_ready, p0_req_ready}),
          (k % 2 == 0) ? word_t'(2'b01) : word_t'(2'b10));
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    resp_ready = 2'b00;

    // Backpressure on p1: two reads accepted, third stalls until one pop.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 12'h0A0;
    @(negedge clk);
    chk("bp_acc0", word_t'(p1_req_ready), word_t'(1'b1));
    @(posedge clk);
    #1;
    req_addr[1] = 12'hFFF;
    @(negedge clk);
    chk("bp_acc1", word_t'(p1_req_ready), word_t'(1'b1));
    @(posedge clk);
    #1;
    req_addr[1] = 12'h005;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("bp_stall_%0d", s), word_t'(p1_req_ready), '0);
    end
    chk("bp_head", p1_resp_rdata, mixed);
    resp_ready[1] = 1'b1;
    #1;
    chk("bp_pop_accept", word_t'(p1_req_ready), word_t'(1'b1));
    @(posedge clk);
    #1;
    resp_ready[1] = 1'b0;
    req_valid[1]  = 1'b0;
    get_resp(1, pat123, "bp_data1");
    get_resp(1, a5, "bp_data2");

    // Single port, continuous reads with resp_ready high: no bubbles.
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 12'h005;
    resp_ready[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("stream_ready_%0d", k), word_t'(p0_req_ready), word_t'(1'b1));
      if (k >= 2) begin
        chk($sformatf("stream_valid_%0d", k), word_t'(p0_resp_valid), word_t'(1'b1));
        chk($sformatf("stream_data_%0d", k), p0_resp_rdata, a5);
      end
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resp_ready[0] = 1'b0;

    // Idle with X on the macro read bus.
    drive_x = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("idle_ctl_%0d", k),
          word_t'({sram_ce_in, sram_we_in, |sram_addr_in, p1_resp_valid, p0_resp_valid}), '0);
      chk($sformatf("idle_wd_%0d", k), sram_wd_in | sram_w_mask_in, '0);
    end
    drive_x = 1'b0;
    @(posedge clk);
    #1;

    // Reset one edge after a p0 read: response dropped, prior write kept, p0 wins next.
    do_req(1, 1'b1, 12'h200, cafe, ones, "pre_rst_wr");
    do_req(0, 1'b0, 12'h005, '0, '0, "pre_rst_rd");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", word_t'(p0_resp_valid), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_empty_%0d", k), word_t'({p1_resp_valid, p0_resp_valid}), '0);
    end
    @(posedge clk);
    #1;
    req_we       = 2'b11;
    req_addr[0]  = 12'h300;
    req_addr[1]  = 12'h300;
    req_wdata[0] = '0;
    req_wdata[1] = '0;
    req_wmask[0] = ones;
    req_wmask[1] = ones;
    req_valid    = 2'b11;
    @(negedge clk);
    chk("rst_first_grant", word_t'({p1_req_ready, p0_req_ready}), word_t'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    do_req(1, 1'b0, 12'h200, '0, '0, "post_rst_rd");
    get_resp(1, cafe, "rst_wr_kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
